// File: rtl/dsp_fe_pkg.sv
// Shared constants and helpers for the DSP front-end lane glue (transmit and receive sides).
// Latency: n/a (package).
// Backpressure: n/a (package).
package dsp_fe_pkg;

  // Default geometry shared with the receive-side retime/repack glue
  localparam int ADC_WIDTH_DEF     = 6;
  localparam int DES_OUT_WIDTH_DEF = 4;
  localparam int SER_WIDTH_DEF     = 2;

  // Fill state of the transposed block buffer
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fill_state_e;

  // Beat counter width; a single-beat gearbox still carries a 1-bit index
  function automatic int beat_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/dsp_fe_lane_ser_glue_if.sv
// Block-in / beat-out bundle between the sample domain, the lane glue and the SER lanes.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the block side; the beat side is valid-only.
interface dsp_fe_lane_ser_glue_if #(
  parameter int ADC_WIDTH     = dsp_fe_pkg::ADC_WIDTH_DEF,
  parameter int DES_OUT_WIDTH = dsp_fe_pkg::DES_OUT_WIDTH_DEF,
  parameter int SER_WIDTH     = dsp_fe_pkg::SER_WIDTH_DEF
);
  import dsp_fe_pkg::*;

  localparam int BEAT_W = beat_cnt_w(DES_OUT_WIDTH / SER_WIDTH);

  logic                                    i_valid;
  logic                                    o_ready;
  logic [DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0] i_dat_da_lane;
  logic [ADC_WIDTH-1:0][SER_WIDTH-1:0]     o_dat_ad_lane;
  logic                                    o_valid;
  logic [BEAT_W-1:0]                       o_beat;

  modport master (
    output i_valid, i_dat_da_lane,
    input  o_ready, o_dat_ad_lane, o_valid, o_beat
  );

  modport slave (
    input  i_valid, i_dat_da_lane,
    output o_ready, o_dat_ad_lane, o_valid, o_beat
  );

endinterface

// File: rtl/dsp_fe_lane_transpose.sv
// Transposes a sample-major block into bit-lane-major form: lanes_o[i][j] = blk_i[j][i].
// Latency: combinational, zero cycles.
// Backpressure: none.
module dsp_fe_lane_transpose #(
  parameter int ADC_WIDTH     = 6,
  parameter int DES_OUT_WIDTH = 4
) (
  input  logic [DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0] blk_i,
  output logic [ADC_WIDTH-1:0][DES_OUT_WIDTH-1:0] lanes_o
);

  // Bit i of sample j becomes bit j of lane i, keeping the earliest sample at the lane LSB
  always_comb begin
    lanes_o = '0;
    for (int i = 0; i < ADC_WIDTH; i++) begin
      for (int j = 0; j < DES_OUT_WIDTH; j++) begin
        lanes_o[i][j] = blk_i[j][i];
      end
    end
  end

endmodule

// File: rtl/dsp_fe_lane_ser_glue.sv
// Transposes sample-major blocks to lane-major and gearboxes each lane into SER_WIDTH-bit beats.
// Latency: block accepted in cycle N puts beat 0 out in cycle N+2; RATIO beats on consecutive cycles.
// Backpressure: o_ready only while empty or on the last beat; a missing block there drains and flags underrun.
module dsp_fe_lane_ser_glue #(
  parameter int ADC_WIDTH     = dsp_fe_pkg::ADC_WIDTH_DEF,
  parameter int DES_OUT_WIDTH = dsp_fe_pkg::DES_OUT_WIDTH_DEF,
  parameter int SER_WIDTH     = dsp_fe_pkg::SER_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_clr_underrun,
  output logic                  o_underrun,
  dsp_fe_lane_ser_glue_if.slave bus
);
  import dsp_fe_pkg::*;

  localparam int RATIO = DES_OUT_WIDTH / SER_WIDTH;
  localparam int BW    = beat_cnt_w(RATIO);

  if ((DES_OUT_WIDTH % SER_WIDTH) != 0) begin : g_bad_ser_width
    $error("DES_OUT_WIDTH must be a multiple of SER_WIDTH");
  end

  fill_state_e                             state_q, state_d;
  logic [BW-1:0]                           cnt_q, cnt_d;
  logic [ADC_WIDTH-1:0][DES_OUT_WIDTH-1:0] lane_buf_q;
  logic [ADC_WIDTH-1:0][DES_OUT_WIDTH-1:0] tp_lanes;
  logic [ADC_WIDTH-1:0][SER_WIDTH-1:0]     slice;
  logic [ADC_WIDTH-1:0][SER_WIDTH-1:0]     dat_q;
  logic                                    vld_q;
  logic [BW-1:0]                           beat_q;
  logic                                    underrun_q;
  logic                                    last_beat;
  logic                                    ready;
  logic                                    accept;
  logic                                    load;
  logic                                    underrun_set;

  dsp_fe_lane_transpose #(
    .ADC_WIDTH     (ADC_WIDTH),
    .DES_OUT_WIDTH (DES_OUT_WIDTH)
  ) u_transpose (
    .blk_i   (bus.i_dat_da_lane),
    .lanes_o (tp_lanes)
  );

  // A new block can land while empty, or exactly on the last beat so the stream stays gapless
  assign last_beat = (cnt_q == BW'(RATIO - 1));
  assign ready     = i_en && ((state_q == ST_EMPTY) || last_beat);
  assign accept    = bus.i_valid && ready;

  // Select the current beat's SER_WIDTH-bit window from every lane
  always_comb begin
    slice = '0;
    for (int i = 0; i < ADC_WIDTH; i++) begin
      slice[i] = lane_buf_q[i][int'(cnt_q) * SER_WIDTH +: SER_WIDTH];
    end
  end

  // Next-state: advance through beats, reload on the last beat or drain and flag underrun
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    underrun_set = 1'b0;
    if (i_en) begin
      case (state_q)
        ST_FULL: begin
          if (!last_beat) begin
            cnt_d = cnt_q + BW'(1);
          end else begin
            cnt_d = '0;
            if (accept) begin
              load = 1'b1;
            end else begin
              state_d      = ST_EMPTY;
              underrun_set = 1'b1;
            end
          end
        end
        default: begin
          if (accept) begin
            load    = 1'b1;
            state_d = ST_FULL;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // Fill state and beat counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transposed block buffer, loaded on accept
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_buf_q <= '0;
    end else if (load) begin
      lane_buf_q <= tp_lanes;
    end
  end

  // Registered beat outputs so SER samples clean flops; held while disabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dat_q  <= '0;
      vld_q  <= 1'b0;
      beat_q <= '0;
    end else if (i_en) begin
      if (state_q == ST_FULL) begin
        dat_q  <= slice;
        vld_q  <= 1'b1;
        beat_q <= cnt_q;
      end else begin
        dat_q <= '0;
        vld_q <= 1'b0;
      end
    end
  end

  // Sticky underrun; a same-cycle set beats the clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      underrun_q <= 1'b0;
    end else if (i_en) begin
      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (i_clr_underrun) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_dat_ad_lane = dat_q;
  assign bus.o_valid       = vld_q;
  assign bus.o_beat        = beat_q;
  assign o_underrun        = underrun_q;

endmodule

// File: tb/tb_dsp_fe_lane_ser_glue.sv
// Directed and randomized bench for the transmit lane glue, RATIO=2 and RATIO=1 instances.
// Latency: expects beat 0 two cycles after accept.
// Backpressure: drives valid against the DUT ready and tracks accepts in a reference queue.
module tb_dsp_fe_lane_ser_glue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, clr_a = 1'b0, underrun_a;
  logic en_b = 1'b0, clr_b = 1'b0, underrun_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp_fe_lane_ser_glue_if #(.ADC_WIDTH(6), .DES_OUT_WIDTH(4), .SER_WIDTH(2)) bus_a ();
  dsp_fe_lane_ser_glue_if #(.ADC_WIDTH(6), .DES_OUT_WIDTH(4), .SER_WIDTH(4)) bus_b ();

  dsp_fe_lane_ser_glue #(.ADC_WIDTH(6), .DES_OUT_WIDTH(4), .SER_WIDTH(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_clr_underrun(clr_a),
    .o_underrun(underrun_a), .bus(bus_a)
  );

  dsp_fe_lane_ser_glue #(.ADC_WIDTH(6), .DES_OUT_WIDTH(4), .SER_WIDTH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_clr_underrun(clr_b),
    .o_underrun(underrun_b), .bus(bus_b)
  );

  // Reference: lane i, beat k, bit b carries bit i of sample k*sw+b (sample j bit i = blk[j*6+i])
  function automatic logic [23:0] model_beat(input logic [23:0] blk, input int k, input int sw);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++)
      for (int b = 0; b < sw; b++)
        r[i*sw + b] = blk[(k*sw + b)*6 + i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat_a(input string tag, input logic [23:0] blk, input int k);
    chk({tag, "_vld"}, 32'(bus_a.o_valid), 32'd1);
    chk({tag, "_beat"}, 32'(bus_a.o_beat), 32'(k));
    chk({tag, "_dat"}, 32'(bus_a.o_dat_ad_lane), 32'(model_beat(blk, k, 2)));
  endtask

  logic [23:0] blk_s, blk_x, blk_u2, blk_r1, blk_r2, blk_r3;
  logic [23:0] blks[8];
  logic [23:0] blkb[10];
  logic [23:0] exp_dat_q[$];
  int          exp_beat_q[$];

  initial begin
    int acc, last_acc, run, maxrun;
    bus_a.i_valid = 1'b0; bus_a.i_dat_da_lane = '0;
    bus_b.i_valid = 1'b0; bus_b.i_dat_da_lane = '0;

    // ---- reset state ----
    #2;
    chk("rst_vld", 32'(bus_a.o_valid), 0);
    chk("rst_dat", 32'(bus_a.o_dat_ad_lane), 0);
    chk("rst_beat", 32'(bus_a.o_beat), 0);
    chk("rst_underrun", 32'(underrun_a), 0);
    chk("rst_ready_dis", 32'(bus_a.o_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    en_a = 1'b1;
    #1 chk("idle_ready", 32'(bus_a.o_ready), 1);

    // ---- single block: 01,02,04,3F ----
    step();
    bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = {6'h3F, 6'h04, 6'h02, 6'h01};
    #1 chk("sb_ready", 32'(bus_a.o_ready), 1);
    step(); bus_a.i_valid = 1'b0;
    #1 chk("sb_n1_vld", 32'(bus_a.o_valid), 0);
    step(); #1;
    chk("sb_n2_vld", 32'(bus_a.o_valid), 1);
    chk("sb_n2_beat", 32'(bus_a.o_beat), 0);
    chk("sb_n2_dat", 32'(bus_a.o_dat_ad_lane), 32'h009);
    step(); #1;
    chk("sb_n3_vld", 32'(bus_a.o_valid), 1);
    chk("sb_n3_beat", 32'(bus_a.o_beat), 1);
    chk("sb_n3_dat", 32'(bus_a.o_dat_ad_lane), 32'hABA);
    step(); #1;
    chk("sb_n4_vld", 32'(bus_a.o_valid), 0);
    chk("sb_n4_underrun", 32'(underrun_a), 1);

    // ---- enable stall after beat 0 ----
    blk_s = 24'($urandom()); blk_x = 24'($urandom());
    step(); bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = blk_s;
    #1 chk("st_ready", 32'(bus_a.o_ready), 1);
    step(); bus_a.i_valid = 1'b0;
    step(); #1 chk_beat_a("st_b0", blk_s, 0);
    en_a = 1'b0; bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = blk_x;
    #1 chk("st_ready_dis", 32'(bus_a.o_ready), 0);
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      chk_beat_a("st_frozen", blk_s, 0);
      chk("st_frozen_ready", 32'(bus_a.o_ready), 0);
    end
    step(); en_a = 1'b1; bus_a.i_valid = 1'b0;
    #1 chk_beat_a("st_resume_hold", blk_s, 0);
    step(); #1 chk_beat_a("st_b1", blk_s, 1);
    step(); #1 chk("st_drain_vld", 32'(bus_a.o_valid), 0);

    // ---- underrun and clear ----
    clr_a = 1'b1;
    step(); clr_a = 1'b0;
    #1 chk("ur_clear_alone", 32'(underrun_a), 0);
    blk_u2 = 24'($urandom());
    bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = 24'($urandom());
    step(); bus_a.i_valid = 1'b0;
    step(); #1 chk("ur_n2_underrun", 32'(underrun_a), 0);
    step(); #1 chk("ur_n3_underrun", 32'(underrun_a), 1);
    step(); bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = blk_u2;
    #1;
    chk("ur_gap1_vld", 32'(bus_a.o_valid), 0);
    chk("ur_gap1_underrun", 32'(underrun_a), 1);
    step(); bus_a.i_valid = 1'b0; clr_a = 1'b1;
    #1;
    chk("ur_gap2_vld", 32'(bus_a.o_valid), 0);
    chk("ur_gap2_underrun", 32'(underrun_a), 1);
    step(); #1;
    chk("ur_cleared", 32'(underrun_a), 0);
    chk_beat_a("ur_b0", blk_u2, 0);
    step(); clr_a = 1'b0;
    #1;
    chk("ur_set_wins", 32'(underrun_a), 1);
    chk_beat_a("ur_b1", blk_u2, 1);
    step(); #1 chk("ur_drain_vld", 32'(bus_a.o_valid), 0);

    // ---- async reset during beat 1 ----
    blk_r1 = 24'($urandom()); blk_r2 = 24'($urandom()); blk_r3 = 24'($urandom());
    bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = blk_r1;
    step(); bus_a.i_valid = 1'b0;
    step(); bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = blk_r2;
    #1 chk_beat_a("ar_b0", blk_r1, 0);
    step(); bus_a.i_valid = 1'b0;
    #1 chk_beat_a("ar_b1", blk_r1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(bus_a.o_valid), 0);
    chk("ar_dat", 32'(bus_a.o_dat_ad_lane), 0);
    chk("ar_beat", 32'(bus_a.o_beat), 0);
    chk("ar_underrun", 32'(underrun_a), 0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(); #1 chk("ar_post_vld", 32'(bus_a.o_valid), 0);
    end
    bus_a.i_valid = 1'b1; bus_a.i_dat_da_lane = blk_r3;
    step(); bus_a.i_valid = 1'b0;
    #1 chk("ar_new_n1_vld", 32'(bus_a.o_valid), 0);
    step(); #1 chk_beat_a("ar_new_b0", blk_r3, 0);
    step(); #1 chk_beat_a("ar_new_b1", blk_r3, 1);
    step();

    // ---- back-to-back: 8 random blocks, valid held high ----
    clr_a = 1'b1; step(); clr_a = 1'b0;
    for (int i = 0; i < 8; i++) blks[i] = 24'($urandom());
    acc = 0; last_acc = -1; run = 0; maxrun = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      bus_a.i_valid = (acc < 8);
      bus_a.i_dat_da_lane = blks[(acc < 8) ? acc : 7];
      #1;
      if (bus_a.o_valid) begin
        if (exp_dat_q.size() == 0) begin
          chk("bb_spurious_vld", 32'(bus_a.o_valid), 0);
        end else begin
          chk("bb_dat", 32'(bus_a.o_dat_ad_lane), 32'(exp_dat_q.pop_front()));
          chk("bb_beat", 32'(bus_a.o_beat), 32'(exp_beat_q.pop_front()));
        end
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (acc < 8) chk("bb_no_underrun", 32'(underrun_a), 0);
      if (bus_a.i_valid && bus_a.o_ready) begin
        for (int k = 0; k < 2; k++) begin
          exp_dat_q.push_back(model_beat(blks[acc], k, 2));
          exp_beat_q.push_back(k);
        end
        if (acc > 0) chk("bb_ready_spacing", 32'(cyc - last_acc), 2);
        last_acc = cyc;
        acc++;
      end
      if (acc == 8 && exp_dat_q.size() == 0 && !bus_a.o_valid) break;
      step();
    end
    bus_a.i_valid = 1'b0;
    chk("bb_accepts", 32'(acc), 8);
    chk("bb_leftover", 32'(exp_dat_q.size()), 0);
    chk("bb_valid_run", 32'(maxrun), 16);
    chk("bb_final_underrun", 32'(underrun_a), 1);

    // ---- RATIO=1 instance: continuous valid ----
    step();
    en_b = 1'b1;
    for (int i = 0; i < 10; i++) blkb[i] = 24'($urandom());
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus_b.i_valid = (cyc < 10);
      bus_b.i_dat_da_lane = blkb[(cyc < 10) ? cyc : 9];
      #1;
      if (cyc < 10) chk("r1_ready", 32'(bus_b.o_ready), 1);
      if (cyc >= 2) begin
        chk("r1_vld", 32'(bus_b.o_valid), 1);
        chk("r1_beat", 32'(bus_b.o_beat), 0);
        chk("r1_dat", 32'(bus_b.o_dat_ad_lane), 32'(model_beat(blkb[cyc-2], 0, 4)));
      end
      step();
    end
    bus_b.i_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
